// File: rtl/rr_sel_mux.sv
// rr_sel_mux: N-channel fixed/round-robin selector with a registered valid/ready output stage.
module rr_sel_mux #(
    parameter int WIDTH = 8,
    parameter int SELW  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [(WIDTH<<SELW)-1:0] in_data,
    input  logic [(1<<SELW)-1:0]     in_valid,
    output logic [(1<<SELW)-1:0]     in_ready,
    input  logic                     mode,
    input  logic [SELW-1:0]          sel,
    output logic [WIDTH-1:0]         out_data,
    output logic [SELW-1:0]          out_ch,
    output logic                     out_valid,
    input  logic                     out_ready
);
    localparam int CH = 1 << SELW;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic             can_load, found, accept;
    logic [SELW-1:0]  grant, cand, idx;

    always_comb begin
        can_load = !out_valid_q || out_ready;
        found    = 1'b0;
        grant    = '0;
        idx      = '0;
        // Rotating priority: first valid channel at or after ptr, wrapping modulo CH.
        for (int i = 0; i < CH; i++) begin
            idx = ptr_q + SELW'(i);
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
        cand           = mode ? grant : sel;
        in_ready       = '0;
        in_ready[cand] = rst_n && can_load && (found || !mode);
        accept         = in_valid[cand] && in_ready[cand];
        out_data_d     = accept ? in_data[cand*WIDTH +: WIDTH] : out_data_q;
        out_ch_d       = accept ? cand : out_ch_q;
        out_valid_d    = accept || (out_valid_q && !out_ready);
        ptr_d          = (accept && mode) ? grant + SELW'(1) : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_rr_sel_mux.sv
// tb_rr_sel_mux: directed stimulus with a cycle-level reference model and literal spot checks.
module tb_rr_sel_mux;
    localparam int W  = 8;
    localparam int S  = 3;
    localparam int CH = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [CH*W-1:0] in_data;
    logic [CH-1:0]   in_valid = '0;
    logic [CH-1:0]   in_ready;
    logic            mode = 1'b0;
    logic [S-1:0]    sel = '0;
    logic [W-1:0]    out_data;
    logic [S-1:0]    out_ch;
    logic            out_valid;
    logic            out_ready = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    rr_sel_mux #(.WIDTH(W), .SELW(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: output register contents and arbitration pointer as plain integers.
    bit       mov = 0;
    logic [W-1:0] mod = '0;
    int       moc = 0;
    int       mptr = 0;

    function automatic logic [CH-1:0] exp_ready();
        logic [CH-1:0] r;
        r = '0;
        if (!rst_n || (mov && !out_ready)) return r;
        if (!mode) begin
            r[sel] = 1'b1;
            return r;
        end
        for (int k = 0; k < CH; k++)
            if (in_valid[(mptr + k) % CH]) begin
                r[(mptr + k) % CH] = 1'b1;
                return r;
            end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [CH-1:0] r;
        int c;
        if (!rst_n) begin
            mov  <= 0;
            mod  <= '0;
            moc  <= 0;
            mptr <= 0;
        end else begin
            r = exp_ready() & in_valid;
            c = -1;
            for (int k = 0; k < CH; k++) if (r[k]) c = k;
            if (c >= 0) begin
                mov <= 1;
                mod <= in_data[c*W +: W];
                moc <= c;
                if (mode) mptr <= (c + 1) % CH;
            end else if (out_ready) mov <= 0;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(exp_ready()));
        chk("out_valid", 32'(out_valid), 32'(mov));
        chk("out_data", 32'(out_data), 32'(mod));
        chk("out_ch", 32'(out_ch), 32'(moc));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    int order[6] = '{0, 2, 5, 7, 0, 2};

    initial begin
        for (int k = 0; k < CH; k++) in_data[k*W +: W] = 8'h10 + 8'(k);
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ready", 32'(in_ready), 0);
        step();
        step();
        rst_n = 1'b1;

        // Fixed-select sweep
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        for (int k = 0; k < CH; k++) begin
            sel = S'(k);
            #1 chk("fix_ready", 32'(in_ready), 32'(1) << k);
            step();
            chk("fix_data", 32'(out_data), 32'h10 + 32'(k));
            chk("fix_ch", 32'(out_ch), 32'(k));
        end

        // Round-robin fairness over 8'b1010_0101
        mode     = 1'b1;
        in_valid = 8'hA5;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_ch", 32'(out_ch), 32'(order[i]));
            chk("rr_valid", 32'(out_valid), 1);
        end

        // Backpressure: pointer is 3, register holds ch2
        in_valid  = 8'hFF;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_ch", 32'(out_ch), 2);
            chk("bp_data", 32'(out_data), 32'h12);
            chk("bp_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_resume_ch", 32'(out_ch), 3);

        // Simultaneous drain and load, then sparse drain
        mode     = 1'b0;
        sel      = 3'd3;
        in_valid = 8'h08;
        step();
        chk("dl_valid", 32'(out_valid), 1);
        chk("dl_data", 32'(out_data), 32'h13);
        in_valid = 8'h00;
        step();
        chk("drain_valid", 32'(out_valid), 0);
        chk("drain_data", 32'(out_data), 32'h13);

        // Reset mid-stream with a word held (pointer is 4)
        mode      = 1'b1;
        in_valid  = 8'hFF;
        out_ready = 1'b0;
        step();
        chk("pre_rst_ch", 32'(out_ch), 4);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_data", 32'(out_data), 0);
        chk("arst_ch", 32'(out_ch), 0);
        chk("arst_ready", 32'(in_ready), 0);
        step();
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post_rst_ch", 32'(out_ch), 0);

        // Mode switch: RR grant 1 (ptr=2), fixed ch6, back to RR from ptr 2
        step();
        chk("ms_rr1", 32'(out_ch), 1);
        mode = 1'b0;
        sel  = 3'd6;
        step();
        chk("ms_fix_ch", 32'(out_ch), 6);
        chk("ms_fix_data", 32'(out_data), 32'h16);
        mode     = 1'b1;
        in_valid = 8'h12;
        step();
        chk("ms_rr_ch", 32'(out_ch), 4);
        chk("ms_rr_data", 32'(out_data), 32'h14);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
